// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
// ps2_rx_fifo
// PS/2 device-to-host receiver feeding a first-word-fall-through FIFO.
// Raw lines are synchronised and glitch-filtered, 11-bit frames
// (start, 8 data LSB first, odd parity, stop) are decoded and each
// completed byte is stored together with its parity-error flag.
// When the FIFO is nearly full the receiver can hold the keyboard off
// by pulling the PS/2 clock low between frames.
//
// Ports
//   clk         system clock
//   reset       asynchronous reset, active low
//   ps2_clk     raw PS/2 clock line
//   ps2_data    raw PS/2 data line
//   ps2_clk_oe  1 = drive PS/2 clock low (open-drain inhibit)
//   rx_data     byte at the FIFO head (0 when empty)
//   rx_perr     parity error flag stored with the head byte
//   rx_valid    FIFO not empty
//   rx_ready    consumer accepts the head entry
//   frame_err   one-cycle pulse: bad stop bit or timeout
//   overflow    one-cycle pulse: completed byte dropped, FIFO full
//   fifo_count  current occupancy
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 16,
  parameter int INHIBIT_EN  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          ps2_clk_oe,
  output logic [7:0]                    rx_data,
  output logic                          rx_perr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------
  // Input conditioning: bit 0 = clock line, bit 1 = data line
  // ---------------------------------------------------------------
  logic [1:0] raw;
  logic [1:0] filt;

  assign raw = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic           s1_reg;
      logic           s2_reg;
      logic           filt_reg;
      logic [FCW-1:0] cnt_reg;

      // The filtered level only moves once the synchronised value has
      // disagreed with it for FILTER_LEN consecutive samples.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_reg   <= 1'b1;
          s2_reg   <= 1'b1;
          filt_reg <= 1'b1;
          cnt_reg  <= '0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == FCW'(FILTER_LEN - 1)) begin
            filt_reg <= s2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  logic clk_prev_reg;
  logic oe_reg;
  logic oe_next;
  logic sample_ev;
  logic sample_bit;

  // Falling edge of the filtered clock; masked while we hold the line low.
  assign sample_ev  = clk_prev_reg & ~filt[0] & ~oe_reg;
  assign sample_bit = filt[1];

  // ---------------------------------------------------------------
  // Frame decoder
  // ---------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [7:0]    byte_reg, byte_next;
  logic [2:0]    bitcnt_reg, bitcnt_next;
  logic          perr_reg, perr_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          push_reg, push_next;
  logic [8:0]    word_reg, word_next;
  logic          ferr_reg, ferr_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_prev_reg <= 1'b1;
      state_reg    <= IDLE;
      byte_reg     <= '0;
      bitcnt_reg   <= '0;
      perr_reg     <= 1'b0;
      tcnt_reg     <= '0;
      push_reg     <= 1'b0;
      word_reg     <= '0;
      ferr_reg     <= 1'b0;
    end else begin
      clk_prev_reg <= filt[0];
      state_reg    <= state_next;
      byte_reg     <= byte_next;
      bitcnt_reg   <= bitcnt_next;
      perr_reg     <= perr_next;
      tcnt_reg     <= tcnt_next;
      push_reg     <= push_next;
      word_reg     <= word_next;
      ferr_reg     <= ferr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    byte_next   = byte_reg;
    bitcnt_next = bitcnt_reg;
    perr_next   = perr_reg;
    tcnt_next   = tcnt_reg + 1'b1;
    push_next   = 1'b0;
    word_next   = word_reg;
    ferr_next   = 1'b0;

    if (state_reg == IDLE) begin
      tcnt_next = '0;
      if (sample_ev && !sample_bit) begin
        state_next  = DATA;
        bitcnt_next = '0;
      end
    end else if (sample_ev) begin
      tcnt_next = '0;
      case (state_reg)
        DATA: begin
          byte_next   = {sample_bit, byte_reg[7:1]};
          bitcnt_next = bitcnt_reg + 1'b1;
          if (bitcnt_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          // Odd parity: data ones plus parity bit must be odd.
          perr_next  = ~(^byte_reg ^ sample_bit);
          state_next = STOP;
        end
        STOP: begin
          if (sample_bit) begin
            push_next = 1'b1;
            word_next = {perr_reg, byte_reg};
          end else begin
            ferr_next = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (tcnt_reg == TW'(TIMEOUT_CYC - 1)) begin
      ferr_next  = 1'b1;
      tcnt_next  = '0;
      state_next = IDLE;
    end
  end

  // ---------------------------------------------------------------
  // FIFO (first-word-fall-through)
  // ---------------------------------------------------------------
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic [8:0]    head;

  assign full  = (count_reg == CW'(FIFO_DEPTH));
  assign pop   = rx_valid & rx_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts.
  assign wr_en = push_reg & (~full | pop);
  assign head  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= word_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      oe_reg     <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      ovf_reg <= push_reg & full & ~pop;
      oe_reg  <= oe_next;
    end
  end

  // Inhibit only starts between frames; release as soon as room returns.
  always_comb begin
    oe_next = 1'b0;
    if (INHIBIT_EN != 0) begin
      oe_next = oe_reg;
      if (state_reg == IDLE && count_reg >= CW'(FIFO_DEPTH - 1)) begin
        oe_next = 1'b1;
      end else if (count_reg < CW'(FIFO_DEPTH - 1)) begin
        oe_next = 1'b0;
      end
    end
  end

  assign rx_valid   = (count_reg != '0);
  assign rx_data    = rx_valid ? head[7:0] : 8'h00;
  assign rx_perr    = rx_valid & head[8];
  assign fifo_count = count_reg;
  assign frame_err  = ferr_reg;
  assign overflow   = ovf_reg;
  assign ps2_clk_oe = oe_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int FL = 4;
  localparam int TO = 2000;
  localparam int D  = 4;
  localparam int HP = 50;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic rx_ready = 1'b0;

  // dut_a: inhibit enabled, dut_b: inhibit disabled; both see the same lines.
  logic       oe_a, va_a, pe_a, fe_a, ov_a;
  logic [7:0] rd_a;
  logic [2:0] cnt_a;
  logic       oe_b, va_b, pe_b, fe_b, ov_b;
  logic [7:0] rd_b;
  logic [2:0] cnt_b;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(D), .INHIBIT_EN(1)) dut_a (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_oe(oe_a), .rx_data(rd_a), .rx_perr(pe_a), .rx_valid(va_a),
    .rx_ready(rx_ready), .frame_err(fe_a), .overflow(ov_a), .fifo_count(cnt_a));

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(D), .INHIBIT_EN(0)) dut_b (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_oe(oe_b), .rx_data(rd_b), .rx_perr(pe_b), .rx_valid(va_b),
    .rx_ready(rx_ready), .frame_err(fe_b), .overflow(ov_b), .fifo_count(cnt_b));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Pulse monitors: counting high cycles also catches pulses wider than one.
  int cyc = 0;
  int fe_hi_a = 0, fe_hi_b = 0, ov_hi_a = 0, ov_hi_b = 0;
  int fe_last_a = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fe_a) begin fe_hi_a <= fe_hi_a + 1; fe_last_a <= cyc; end
    if (fe_b) fe_hi_b <= fe_hi_b + 1;
    if (ov_a) ov_hi_a <= ov_hi_a + 1;
    if (ov_b) ov_hi_b <= ov_hi_b + 1;
  end

  // Reference model: expected FIFO contents {perr, byte} and pulse counts.
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int exp_fe_a = 0, exp_fe_b = 0, exp_ov_b = 0;
  int last_fall = 0;
  int lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic p, input logic stop);
    return {stop, p, b, 1'b0};
  endfunction

  // Error when the total number of ones in data+parity is even.
  function automatic logic exp_perr(input logic [7:0] b, input logic p);
    return ((($countones(b) + int'(p)) % 2) == 0);
  endfunction

  function automatic logic odd_par(input logic [7:0] b);
    return (($countones(b) % 2) == 0);
  endfunction

  // Device drives data while clock is high, then a clock low phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        tick(10); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(12);
      end else begin
        tick(HP / 2);
      end
      ps2_clk = 1'b0;
      last_fall = cyc;
      tick(HP);
      ps2_clk = 1'b1;
      tick(HP / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic stop, input int glitch_bit);
    logic acc_a;
    logic [8:0] w;
    acc_a = (qa.size() < D - 1); // dut_a holds the clock low once 3 are queued
    send_bits(mk(b, p, stop), 11, glitch_bit);
    w = {exp_perr(b, p), b};
    if (stop) begin
      if (acc_a) qa.push_back(w);
      if (qb.size() < D) qb.push_back(w);
      else exp_ov_b++;
    end else begin
      if (acc_a) exp_fe_a++;
      exp_fe_b++;
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt_a"}, cnt_a, qa.size());
    chk({tag, "_cnt_b"}, cnt_b, qb.size());
  endtask

  task automatic pop_check(input string tag);
    chk({tag, "_valid_a"}, va_a, qa.size() > 0);
    if (qa.size() > 0) begin
      chk({tag, "_data_a"}, rd_a, qa[0][7:0]);
      chk({tag, "_perr_a"}, pe_a, qa[0][8]);
    end
    chk({tag, "_valid_b"}, va_b, qb.size() > 0);
    if (qb.size() > 0) begin
      chk({tag, "_data_b"}, rd_b, qb[0][7:0]);
      chk({tag, "_perr_b"}, pe_b, qb[0][8]);
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    if (qa.size() > 0) void'(qa.pop_front());
    if (qb.size() > 0) void'(qb.pop_front());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cnt_a"}, cnt_a, 0);   chk({tag, "_cnt_b"}, cnt_b, 0);
    chk({tag, "_valid_a"}, va_a, 0);  chk({tag, "_valid_b"}, va_b, 0);
    chk({tag, "_data_a"}, rd_a, 0);   chk({tag, "_data_b"}, rd_b, 0);
    chk({tag, "_perr_a"}, pe_a, 0);   chk({tag, "_perr_b"}, pe_b, 0);
    chk({tag, "_oe_a"}, oe_a, 0);     chk({tag, "_oe_b"}, oe_b, 0);
    chk({tag, "_ferr_a"}, fe_a, 0);   chk({tag, "_ferr_b"}, fe_b, 0);
    chk({tag, "_ovf_a"}, ov_a, 0);    chk({tag, "_ovf_b"}, ov_b, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic       rp;
    logic       rs;

    // Reset state
    tick(5);
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick(5);

    // 1: clean frame 0x1C, parity 0
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    tick(2);
    chk_counts("t1");
    pop_check("t1");
    chk_counts("t1_after");

    // 2: parity error, then bad stop bit
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    pop_check("t2_perr");
    send_frame(8'hF0, 1'b1, 1'b0, -1);
    tick(2);
    chk("t2_fe_a", fe_hi_a, exp_fe_a);
    chk("t2_fe_b", fe_hi_b, exp_fe_b);
    chk_counts("t2");

    // 3: truncated frame -> timeout
    send_bits(mk(8'hF0, 1'b1, 1'b1), 4, -1);
    exp_fe_a++;
    exp_fe_b++;
    tick(2300);
    chk("t3_fe_a", fe_hi_a, exp_fe_a);
    chk("t3_fe_b", fe_hi_b, exp_fe_b);
    lat = fe_last_a - last_fall;
    chk("t3_latency_window", (lat >= TO - 5) && (lat <= TO + 25), 1);
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    pop_check("t3_after");

    // 4: short clock glitches in idle and mid-frame
    ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(30);
    chk_counts("t4_idle");
    send_frame(8'h5A, 1'b1, 1'b1, 4);
    chk_counts("t4");
    pop_check("t4");
    chk("t4_fe_a", fe_hi_a, exp_fe_a);

    // 5: fill to DEPTH-1 -> inhibit on dut_a only
    send_frame(8'h01, odd_par(8'h01), 1'b1, -1);
    send_frame(8'h02, odd_par(8'h02), 1'b1, -1);
    send_frame(8'h03, odd_par(8'h03), 1'b1, -1);
    tick(3);
    chk_counts("t5");
    chk("t5_oe_a", oe_a, 1);
    chk("t5_oe_b", oe_b, 0);
    pop_check("t5_pop");
    tick(1);
    chk("t5_oe_a_release", oe_a, 0);
    chk("t5_head_a", rd_a, qa[0][7:0]);
    chk("t5_head_b", rd_b, qb[0][7:0]);

    reset = 1'b0;
    tick(3);
    qa.delete();
    qb.delete();
    chk_counts("t5_rst");
    reset = 1'b1;
    tick(5);

    // 6: overflow on dut_b, dut_a held off after three
    for (int i = 0; i < 5; i++) begin
      rb = 8'h11 + 8'(i);
      send_frame(rb, odd_par(rb), 1'b1, -1);
      tick(2);
      chk($sformatf("t6_ovf_b_%0d", i), ov_hi_b, exp_ov_b);
    end
    chk("t6_ovf_a", ov_hi_a, 0);
    chk("t6_oe_a", oe_a, 1);
    chk_counts("t6");
    for (int i = 0; i < D; i++) pop_check($sformatf("t6_pop%0d", i));
    chk_counts("t6_drained");

    // Refill, then reset in the middle of a frame
    send_frame(8'h21, odd_par(8'h21), 1'b1, -1);
    send_frame(8'h22, odd_par(8'h22), 1'b1, -1);
    chk_counts("t6_refill");
    send_bits(mk(8'h77, 1'b0, 1'b1), 5, -1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("t6_midrst");
    tick(3);
    qa.delete();
    qb.delete();
    reset = 1'b1;
    tick(5);
    send_frame(8'h29, 1'b0, 1'b1, -1);
    chk_counts("t6_post");
    pop_check("t6_post");

    // Random frames against the model
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      rp = ($urandom_range(0, 3) == 0) ? ~odd_par(rb) : odd_par(rb);
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rb, rp, rs, -1);
      tick(2);
      chk_counts($sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) pop_check($sformatf("rnd%0d_pop", i));
    end
    chk("rnd_fe_a", fe_hi_a, exp_fe_a);
    chk("rnd_fe_b", fe_hi_b, exp_fe_b);
    chk("rnd_ovf_b", ov_hi_b, exp_ov_b);
    chk("rnd_ovf_a", ov_hi_a, 0);
    for (int i = 0; i < D; i++) pop_check($sformatf("drain%0d", i));
    chk_counts("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver with a buffered output stream. It synchronises and glitch-filters the raw ps2_clk/ps2_data lines, then decodes 11-bit frames: start, 8 data bits LSB first, odd parity, stop. Decoded bytes go into a FIFO with a valid/ready interface. It can inhibit the device by pulling ps2_clk low when the FIFO is nearly full. It sits between the keyboard pins and the game/control logic of the Minesweeper design.

Parameters:
FILTER_LEN, 8, consecutive clk cycles a synchronised line must hold a new level before the filtered level changes (>=1)
TIMEOUT_CYC, 100000, clk cycles without a filtered ps2_clk falling edge before a partial frame is aborted
FIFO_DEPTH, 16, FIFO entries; power of two, >=2
INHIBIT_EN, 1, 1 enables clock-inhibit flow control

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low
ps2_clk  input  1  raw PS/2 clock line
ps2_data  input  1  raw PS/2 data line
ps2_clk_oe  output  1  1 = drive PS/2 clock low (open-drain inhibit)
rx_data  output  8  byte at the FIFO head
rx_perr  output  1  parity error flag stored with the head byte
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts the head entry
frame_err  output  1  one-cycle pulse: bad stop bit or timeout
overflow  output  1  one-cycle pulse: completed byte dropped because the FIFO was full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; FIFO empty; fifo_count 0; rx_valid, frame_err, overflow, ps2_clk_oe = 0; rx_data 0; rx_perr 0; synchronisers and filtered levels = 1.
- Input path: 2-flop synchroniser per line, then the filter. The filtered level takes the synchronised value after FILTER_LEN consecutive equal samples that differ from the current filtered level. A shorter excursion is ignored.
- A sample event is a 1->0 transition of filtered clk. The filtered data level is sampled on that same cycle. Edge-to-event latency is 2+FILTER_LEN cycles.
- Sample events are ignored while ps2_clk_oe=1.
- FSM:
  - IDLE: on an event with data=0, go to DATA and set bitcnt=0. An event with data=1 is ignored.
  - DATA: on each event, shift data in at bit 7 and shift right, so the first bit ends up at bit 0. After the 8th bit, go to PARITY.
  - PARITY: on an event, latch p and set perr = ~(^byte ^ p), i.e. odd parity is required. Go to STOP.
  - STOP: on an event with data=1, push {perr, byte} and go to IDLE. With data=0, pulse frame_err, discard the byte and go to IDLE.
- Timeout: the cycle counter clears on every event and in IDLE. In DATA/PARITY/STOP, when the counter reaches TIMEOUT_CYC, pulse frame_err, discard and go to IDLE.
- Push timing: the push occurs on the cycle after the stop event. rx_valid rises on the next cycle if the FIFO was empty.
- FIFO is first-word-fall-through. rx_data and rx_perr reflect the head whenever rx_valid=1 and are held stable while rx_valid=1 and rx_ready=0. Pop when rx_valid & rx_ready. rx_ready with empty FIFO: no effect.
- Push and pop on the same cycle:
  - With the FIFO full: the push is accepted, fifo_count stays FIFO_DEPTH, no overflow.
  - Otherwise: count is unchanged.
- Push when full without a pop: overflow pulse, byte dropped, FIFO contents unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count saturates at neither end because it is correctly maintained.
- Inhibit (INHIBIT_EN=1):
  - Assert ps2_clk_oe on the cycle after state==IDLE and fifo_count>=FIFO_DEPTH-1. It is never asserted mid-frame.
  - Deassert on the cycle after fifo_count<FIFO_DEPTH-1.
  - With INHIBIT_EN=0, ps2_clk_oe is constant 0.
- frame_err and overflow never assert on the same cycle as each other's cause being absent. Each pulse lasts exactly one cycle.
- Reset mid-frame: everything returns to reset values immediately and the partial frame is lost. The first frame after reset release decodes normally.

Test Plan:
(Bench uses FILTER_LEN=4, TIMEOUT_CYC=2000, PS/2 half-period 50 cycles.)
1. Frame 0x1C, parity 0, stop 1 -> one push; rx_valid=1, rx_data=0x1C, rx_perr=0; rx_ready pulse -> rx_valid=0, fifo_count 0.
2. Frame 0x1C with parity 1 -> rx_data=0x1C, rx_perr=1. Frame 0xF0 with stop bit 0 -> frame_err pulse of 1 cycle, fifo_count unchanged.
3. Start bit plus 3 data bits, then clock idle high -> frame_err exactly once, about 2000 cycles after the last event. Next frame 0xF0 (parity 1) -> rx_data=0xF0, rx_perr=0.
4. Glitch: ps2_clk low for 3 cycles during IDLE and mid-frame -> no extra bit sampled. Frame 0x5A is still decoded correctly with rx_perr=0.
5. FIFO_DEPTH=4, INHIBIT_EN=1, rx_ready=0: three frames 0x01, 0x02, 0x03 -> fifo_count 3, ps2_clk_oe=1. Pop one -> ps2_clk_oe=0 next cycle, head=0x02.
6. FIFO_DEPTH=4, INHIBIT_EN=0: five frames 0x11..0x15 without pops -> overflow pulse on the 5th, FIFO holds 0x11..0x14 in order. Then assert reset mid-frame -> all outputs 0, fifo_count 0; the next frame 0x29 is decoded correctly.
